// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with req/ack data-memory access and MEM/WB pipeline register.
// Stalls upstream while an aligned load/store is outstanding; aborts after MAX_WAIT cycles.
module mem_wb_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] data_rt_in,
    input  logic [4:0]  regw_addr_in,
    input  logic        wb_wen_in,
    input  logic        mem_ren_in,
    input  logic        mem_wen_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_sext_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  regw_addr_out,
    output logic        wb_wen_out,
    output logic        align_err_out,
    output logic        bus_err_out
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic [31:0] rbuf, rd, ld, wdata_nx;
    logic [15:0] lh;
    logic [7:0] lb;
    logic [3:0] be_nx;
    logic mop, mis, amop, go, timeout, stall;
    always_comb begin
        mop = valid_in & (mem_ren_in | mem_wen_in);
        mis = mem_size_in == 2'b00 ? 1'b0 : mem_size_in == 2'b01 ? alu_res_in[0] : |alu_res_in[1:0];
        amop = mop & ~mis;
        go = state == IDLE & amop & en;
        timeout = state == WAIT & ~dmem_ack & wait_cnt == CW'(MAX_WAIT - 1);
        stall = amop & ~((state == WAIT & dmem_ack) | state == DONE | timeout);
        stall_out = rst & stall;
        state_nx = state == IDLE ? (go ? WAIT : IDLE)
                 : state == WAIT ? (dmem_ack ? (en ? IDLE : DONE) : timeout ? IDLE : WAIT)
                 : (en ? IDLE : DONE);
        // Data acked while held lives in rbuf until the enabled capture edge
        rd = state == DONE ? rbuf : dmem_rdata;
        lb = rd[{alu_res_in[1:0], 3'b000} +: 8];
        lh = alu_res_in[1] ? rd[31:16] : rd[15:0];
        ld = mem_size_in == 2'b00 ? {{24{mem_sext_in & lb[7]}}, lb}
           : mem_size_in == 2'b01 ? {{16{mem_sext_in & lh[15]}}, lh} : rd;
        be_nx = mem_size_in == 2'b00 ? 4'b0001 << alu_res_in[1:0]
              : mem_size_in == 2'b01 ? (alu_res_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_nx = mem_size_in == 2'b00 ? {4{data_rt_in[7:0]}}
                 : mem_size_in == 2'b01 ? {2{data_rt_in[15:0]}} : data_rt_in;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wait_cnt <= '0;
            rbuf <= '0;
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            dmem_addr <= '0;
            dmem_be <= '0;
            dmem_wdata <= '0;
        end else begin
            state <= state_nx;
            wait_cnt <= go ? '0 : (state == WAIT & ~dmem_ack) ? wait_cnt + CW'(1) : wait_cnt;
            if (state == WAIT & dmem_ack & ~en)
                rbuf <= dmem_rdata;
            if (go) begin
                dmem_req <= 1'b1;
                dmem_we <= mem_wen_in;
                dmem_addr <= {alu_res_in[31:2], 2'b00};
                dmem_be <= be_nx;
                dmem_wdata <= wdata_nx;
            end else if (state == WAIT & (dmem_ack | timeout)) begin
                dmem_req <= 1'b0;
                dmem_we <= 1'b0;
                dmem_addr <= '0;
                dmem_be <= '0;
                dmem_wdata <= '0;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            pc_out <= '0;
            wb_data_out <= '0;
            regw_addr_out <= '0;
            wb_wen_out <= 1'b0;
            align_err_out <= 1'b0;
            bus_err_out <= 1'b0;
        end else if (en) begin
            if (stall) begin
                valid_out <= 1'b0;
                wb_wen_out <= 1'b0;
                align_err_out <= 1'b0;
                bus_err_out <= 1'b0;
            end else begin
                valid_out <= valid_in;
                pc_out <= pc_in;
                regw_addr_out <= regw_addr_in;
                wb_data_out <= mem_ren_in ? ld : alu_res_in;
                align_err_out <= mop & mis;
                bus_err_out <= timeout;
                wb_wen_out <= wb_wen_in & valid_in & ~(mop & mis) & ~timeout;
            end
        end
    end
endmodule
